// File: rtl/sc_cpu_pkg.sv
// Shared types for the single-cycle CPU: FSM state, next-PC select, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sc_cpu_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } pc_state_t;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_t;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   // Branch displacement in bytes: sign-extended word offset.
   function automatic logic [31:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/sc_npc_mux.sv
// Next-PC priority select (JR > J/JAL > branch > sequential) and redirect flag.
// Latency: purely combinational.
// Backpressure: none; the caller gates the result with its own FSM state.
module sc_npc_mux
   import sc_cpu_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic        beq,
   input  logic        bne,
   input  logic        blez,
   input  logic        jmp,
   input  logic        jal,
   input  logic        jr,
   input  logic        equal,
   input  logic        rs_le_zero,
   input  logic [15:0] imm16,
   input  logic [25:0] target26,
   input  logic [31:0] reg_rs,
   output logic [31:0] next_pc,
   output logic        taken
);

   npc_sel_t sel;

   always_comb begin
      sel = NPC_SEQ;
      if (jr)
         sel = NPC_JR;
      else if (jmp || jal)
         sel = NPC_J;
      else if ((beq && equal) || (bne && !equal) || (blez && rs_le_zero))
         sel = NPC_BR;
   end

   always_comb begin
      next_pc = pc_plus4;
      case (sel)
         NPC_JR:  next_pc = reg_rs & ~32'h0000_0003;
         NPC_J:   next_pc = {pc_plus4[31:28], target26, 2'b00};
         NPC_BR:  next_pc = pc_plus4 + br_offset(imm16);
         default: next_pc = pc_plus4;
      endcase
   end

   assign taken = (sel != NPC_SEQ);

endmodule

// File: rtl/sc_pc_unit.sv
// PC register, RUN/HALT syscall FSM and optional statistics (SC_PC_STATS_EN).
// Latency: next PC is combinational, PC updates on the next enabled edge; no delay slot.
// Backpressure: En=0 freezes PC, state and counters; HALT waits for a Go pulse.
module sc_pc_unit
   import sc_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          IMEM_AW  = 10,
   parameter int          CNT_W    = 32
)(
   input  logic [4:0]         LOGISIM_CLOCK_TREE_0,
   input  logic               Reset_n,
   input  logic               En,
   input  logic               Beq,
   input  logic               Bne,
   input  logic               BLEZ,
   input  logic               JMP,
   input  logic               JAL,
   input  logic               JR,
   input  logic               SysCALL,
   input  logic               Equal,
   input  logic               RsLeZero,
   input  logic               SysHalt,
   input  logic               Go,
   input  logic [15:0]        Imm16,
   input  logic [25:0]        Target26,
   input  logic [31:0]        RegRs,
   output logic [31:0]        PC,
   output logic [31:0]        PC_plus4,
   output logic [IMEM_AW-1:0] IMemAddr,
   output logic               Halted,
   output logic               Taken,
   output logic [CNT_W-1:0]   CycleCnt,
   output logic [CNT_W-1:0]   BranchCnt
);

   logic        clk;
   logic        unused_clk_tree;
   logic [31:0] pc_q;
   logic [31:0] npc;
   logic        mux_taken;
   pc_state_t   state;

   assign clk             = LOGISIM_CLOCK_TREE_0[0];
   assign unused_clk_tree = ^LOGISIM_CLOCK_TREE_0[4:1];

   assign PC       = pc_q;
   assign PC_plus4 = pc_q + 32'd4;
   assign IMemAddr = pc_q[IMEM_AW+1:2];
   assign Halted   = (state == ST_HALT);
   // Redirects only count in RUN and never while reset is held.
   assign Taken    = Reset_n && (state == ST_RUN) && mux_taken;

   sc_npc_mux u_npc_mux (
      .pc_plus4   (PC_plus4),
      .beq        (Beq),
      .bne        (Bne),
      .blez       (BLEZ),
      .jmp        (JMP),
      .jal        (JAL),
      .jr         (JR),
      .equal      (Equal),
      .rs_le_zero (RsLeZero),
      .imm16      (Imm16),
      .target26   (Target26),
      .reg_rs     (RegRs),
      .next_pc    (npc),
      .taken      (mux_taken)
   );

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pc_q  <= RESET_PC;
         state <= ST_RUN;
      end else if (En) begin
         case (state)
            ST_RUN: begin
               // A halting syscall parks the PC on itself; Go is not sampled here.
               if (SysCALL && SysHalt)
                  state <= ST_HALT;
               else
                  pc_q <= npc;
            end
            ST_HALT: begin
               if (Go) begin
                  pc_q  <= PC_plus4;
                  state <= ST_RUN;
               end
            end
         endcase
      end
   end

`ifdef SC_PC_STATS_EN
   logic [CNT_W-1:0] cycle_cnt_q;
   logic [CNT_W-1:0] branch_cnt_q;

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cycle_cnt_q  <= '0;
         branch_cnt_q <= '0;
      end else if (En && (state == ST_RUN)) begin
         cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
         if (Taken)
            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
   end

   assign CycleCnt  = cycle_cnt_q;
   assign BranchCnt = branch_cnt_q;
`else
   assign CycleCnt  = '0;
   assign BranchCnt = '0;
`endif

endmodule

// File: tb/tb_sc_pc_unit.sv
// Bench for sc_pc_unit: directed scenarios then random flow inputs vs a behavioural model.
// Counter expectations follow SC_PC_STATS_EN.
module tb_sc_pc_unit;

   localparam int          IMEM_AW  = 10;
   localparam int          CNT_W    = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic [4:0]         clk_tree;
   logic               rst_n, en;
   logic               beq, bne, blez, jmp, jal, jr, syscall;
   logic               equal, rs_le_zero, sys_halt, go;
   logic [15:0]        imm16;
   logic [25:0]        target26;
   logic [31:0]        reg_rs;
   logic [31:0]        pc, pc_plus4;
   logic [IMEM_AW-1:0] imem_addr;
   logic               halted, taken;
   logic [CNT_W-1:0]   cycle_cnt, branch_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [31:0] m_pc;
   bit          m_halt;
   logic [31:0] m_cyc, m_br;

   sc_pc_unit #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW), .CNT_W(CNT_W)) dut (
      .LOGISIM_CLOCK_TREE_0 (clk_tree),
      .Reset_n   (rst_n),
      .En        (en),
      .Beq       (beq),
      .Bne       (bne),
      .BLEZ      (blez),
      .JMP       (jmp),
      .JAL       (jal),
      .JR        (jr),
      .SysCALL   (syscall),
      .Equal     (equal),
      .RsLeZero  (rs_le_zero),
      .SysHalt   (sys_halt),
      .Go        (go),
      .Imm16     (imm16),
      .Target26  (target26),
      .RegRs     (reg_rs),
      .PC        (pc),
      .PC_plus4  (pc_plus4),
      .IMemAddr  (imem_addr),
      .Halted    (halted),
      .Taken     (taken),
      .CycleCnt  (cycle_cnt),
      .BranchCnt (branch_cnt)
   );

   initial clk_tree = 5'b0;
   always #5 clk_tree[0] = ~clk_tree[0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Model: what the next PC would be and whether it is a redirect.
   function automatic logic [32:0] model_npc();
      logic [31:0] p4;
      p4 = m_pc + 32'd4;
      if (m_halt)                                  return {1'b0, p4};
      if (jr)                                      return {1'b1, (reg_rs / 4) * 4};
      if (jmp || jal)                              return {1'b1, p4[31:28], target26, 2'b00};
      if ((beq && equal) || (bne && !equal) || (blez && rs_le_zero))
         return {1'b1, p4 + 32'(int'($signed(imm16)) * 4)};
      return {1'b0, p4};
   endfunction

   task automatic clear_inputs();
      en = 1; beq = 0; bne = 0; blez = 0; jmp = 0; jal = 0; jr = 0; syscall = 0;
      equal = 0; rs_le_zero = 0; sys_halt = 0; go = 0;
      imm16 = '0; target26 = '0; reg_rs = '0;
   endtask

   task automatic rand_inputs();
      en         = ($urandom_range(7) != 0);
      beq        = ($urandom_range(5) == 0);
      bne        = ($urandom_range(5) == 0);
      blez       = ($urandom_range(5) == 0);
      jmp        = ($urandom_range(9) == 0);
      jal        = ($urandom_range(9) == 0);
      jr         = ($urandom_range(11) == 0);
      syscall    = ($urandom_range(11) == 0);
      sys_halt   = ($urandom_range(1) == 0);
      go         = ($urandom_range(2) == 0);
      equal      = 1'($urandom);
      rs_le_zero = 1'($urandom);
      imm16      = 16'($urandom);
      target26   = 26'($urandom);
      reg_rs     = $urandom;
   endtask

   // Check all outputs against the model before the edge, then advance both.
   task automatic step(input string tag);
      logic [32:0] n;
      logic [31:0] exp_cyc, exp_br;
      @(negedge clk_tree[0]);
      n = model_npc();
`ifdef SC_PC_STATS_EN
      exp_cyc = m_cyc; exp_br = m_br;
`else
      exp_cyc = '0; exp_br = '0;
`endif
      chk({tag, ".pc"},     pc, m_pc);
      chk({tag, ".pc4"},    pc_plus4, m_pc + 32'd4);
      chk({tag, ".imem"},   32'(imem_addr), 32'(m_pc[IMEM_AW+1:2]));
      chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
      chk({tag, ".taken"},  32'(taken), 32'(n[32]));
      chk({tag, ".cyc"},    cycle_cnt, exp_cyc);
      chk({tag, ".br"},     branch_cnt, exp_br);
      @(posedge clk_tree[0]);
      #1;
      if (en) begin
         if (!m_halt) begin
            m_cyc++;
            if (n[32]) m_br++;
            if (syscall && sys_halt) m_halt = 1;
            else                     m_pc = n[31:0];
         end else if (go) begin
            m_pc   = m_pc + 32'd4;
            m_halt = 0;
         end
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_PC; m_halt = 0; m_cyc = '0; m_br = '0;
   endtask

   // Reset is released with En low so the release edge does not advance state.
   task automatic release_reset();
      en = 0;
      @(negedge clk_tree[0]);
      #1 rst_n = 1;
      @(posedge clk_tree[0]);
      #1 clear_inputs();
   endtask

   task automatic goto_pc(input logic [31:0] a);
      clear_inputs(); jr = 1; reg_rs = a;
      step("goto");
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      model_reset();
      beq = 1; equal = 1;
      #12;
      chk("rst.pc", pc, RESET_PC);
      chk("rst.halted", 32'(halted), 32'd0);
      chk("rst.taken", 32'(taken), 32'd0);
      chk("rst.cyc", cycle_cnt, 32'd0);
      chk("rst.br", branch_cnt, 32'd0);
      release_reset();

      for (int i = 0; i < 3; i++) step("seq");
      chk("seq.pc3", pc, 32'h0000_000C);

      goto_pc(32'h0000_0040);
      beq = 1; equal = 1; imm16 = 16'hFFFE;
      step("beq_t");
      chk("beq_back", pc, 32'h0000_003C);
      goto_pc(32'h0000_0040);
      beq = 1; equal = 0; imm16 = 16'hFFFE;
      step("beq_nt");
      chk("beq_fall", pc, 32'h0000_0044);

      goto_pc(32'h1000_0010);
      jal = 1; target26 = 26'h000_0100;
      step("jal");
      chk("jal.pc", pc, 32'h1000_0400);
      clear_inputs();
      jr = 1; jmp = 1; reg_rs = 32'h0000_2003; target26 = 26'h3FF_FFFF;
      step("jr_jmp");
      chk("jr_wins", pc, 32'h0000_2000);

      goto_pc(32'h0000_0080);
      syscall = 1; sys_halt = 1; go = 1;
      step("sys_halt");
      chk("halt.pc", pc, 32'h0000_0080);
      chk("halt.flag", 32'(halted), 32'd1);
      clear_inputs(); jmp = 1; target26 = 26'h123;
      step("halt_hold");
      clear_inputs(); go = 1;
      step("resume");
      chk("resume.pc", pc, 32'h0000_0084);
      chk("resume.flag", 32'(halted), 32'd0);
      goto_pc(32'h0000_0080);
      syscall = 1; sys_halt = 0;
      step("sys_nohalt");
      chk("nohalt.pc", pc, 32'h0000_0084);

      clear_inputs(); en = 0; jmp = 1; target26 = 26'h3;
      for (int i = 0; i < 3; i++) step("stall");
      chk("stall.pc", pc, 32'h0000_0084);

      // Statistics window: 10 RUN cycles, 3 of them taken branches.
      rst_n = 0; model_reset();
      #1;
      release_reset();
      for (int i = 0; i < 10; i++) begin
         clear_inputs();
         if (i == 2 || i == 5 || i == 7) begin bne = 1; equal = 0; imm16 = 16'h0003; end
         step("stats");
      end
`ifdef SC_PC_STATS_EN
      chk("stats.cyc10", cycle_cnt, 32'd10);
      chk("stats.br3", branch_cnt, 32'd3);
`else
      chk("stats.cyc0", cycle_cnt, 32'd0);
      chk("stats.br0", branch_cnt, 32'd0);
`endif

      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         step("rand");
      end

      clear_inputs(); syscall = 1; sys_halt = 1;
      step("halt2");
      clear_inputs();
      #3 rst_n = 0;
      #1;
      chk("arst.pc", pc, RESET_PC);
      chk("arst.halted", 32'(halted), 32'd0);
      model_reset();
      release_reset();
      for (int i = 0; i < 2; i++) step("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sc_pc_unit.md
Name: sc_pc_unit

Overview:
- Program-counter and next-PC stage of the single-cycle MIPS CPU (Tetris build).
- Holds PC, drives the instruction-memory word address, and consumes the hard-wired controller's flow-control outputs (Beq, Bne, BLEZ, JMP, JAL, JR, SysCALL).
- Computes next PC and implements the halt/resume state machine for halting syscalls.
- Supplies PC+4 to the JAL link-write path.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 10, width of the word address driven to instruction memory.
- CNT_W, 32, width of the statistics counters.

Ports:
- LOGISIM_CLOCK_TREE_0  in  5  clock tree; bit 0 is the clock, rising edge active; bits 4:1 unused.
- Reset_n  in  1  asynchronous active-low reset.
- En  in  1  global advance enable; 0 freezes all state.
- Beq, Bne, BLEZ, JMP, JAL, JR, SysCALL  in  1 each  controller decode.
- Equal  in  1  ALU compare, rs==rt.
- RsLeZero  in  1  rs <= 0 (signed).
- SysHalt  in  1  syscall is a halt request ($v0==10).
- Go  in  1  resume pulse from board button, already synchronised.
- Imm16  in  16  branch offset field.
- Target26  in  26  jump target field.
- RegRs  in  32  JR target.
- PC  out  32  current PC.
- PC_plus4  out  32  PC+4, for the link path.
- IMemAddr  out  IMEM_AW  PC[IMEM_AW+1:2].
- Halted  out  1  state==HALT.
- Taken  out  1  redirect (branch or jump) chosen this cycle.
- CycleCnt, BranchCnt  out  CNT_W each  statistics counters; see Optional Feature.

Behaviour:
- Reset, async on Reset_n=0:
  - PC=RESET_PC; state=RUN.
  - Halted=0; counters=0.
  - Taken is combinational and is 0 while in reset.
- Sequential updates happen on the rising edge of LOGISIM_CLOCK_TREE_0[0], and only when En=1.
- Next-PC selection in RUN, highest priority first:
  1. JR: RegRs with bits [1:0] forced to 00.
  2. JMP or JAL: {PC_plus4[31:28], Target26, 2'b00}.
  3. Beq&Equal, Bne&~Equal, or BLEZ&RsLeZero: PC_plus4 + (sext(Imm16)<<2), modulo 2^32.
  4. Otherwise: PC_plus4.
- Taken = 1 whenever case 1, 2 or 3 is selected.
- PC_plus4 is PC+4 with wrap-around: 32'hFFFF_FFFC -> 0.
- Latency:
  - Next-PC is combinational from the current-cycle inputs.
  - PC updates on the next edge.
  - Zero-cycle branch penalty; no delay slot.
- State machine RUN/HALT:
  - RUN, SysCALL&SysHalt: PC holds (stays on the syscall); go to HALT. Go in the same cycle is ignored.
  - RUN, SysCALL&~SysHalt: treated as a sequential instruction; PC <= PC_plus4.
  - HALT, Go=0: PC holds. All flow inputs are ignored; Taken=0.
  - HALT, Go=1: PC <= PC_plus4; go to RUN.
- En=0 freezes state, PC and counters. Taken is still computed combinationally, gated to 0 in HALT.
- Reset mid-HALT returns to RUN at RESET_PC.
- Multiple flow inputs asserted together are resolved by the priority above; no error is flagged.

Optional Feature:
- Macro SC_PC_STATS_EN.
- Defined:
  - CycleCnt increments on every enabled edge while in RUN.
  - BranchCnt increments on every enabled edge where Taken=1 and the state is RUN.
  - Both wrap at 2^CNT_W.
- Undefined:
  - Counters are not instantiated.
  - CycleCnt and BranchCnt are tied to 0.
  - Ports remain, so the top level is unchanged.

Decomposition:
- Shared package sc_cpu_pkg:
  - State encoding constants: ST_RUN=1'b0, ST_HALT=1'b1.
  - Next-PC select encoding: NPC_SEQ, NPC_BR, NPC_J, NPC_JR.
  - RESET_PC default.
- One sub-module, sc_npc_mux: combinational next-PC priority and Taken generation.
- Registers, FSM and counters stay in sc_pc_unit.

Test Plan:
- Reset and sequencing: Reset_n low then released, En=1, no flow inputs -> PC 0x0, 0x4, 0x8 on successive edges; IMemAddr 0,1,2.
- Backward branch taken: PC=0x40, Beq=1, Equal=1, Imm16=16'hFFFE -> next PC 0x3C, Taken=1. Same with Equal=0 -> 0x44, Taken=0.
- Jump and register jump:
  - PC=0x1000_0010, JAL=1, Target26=26'h000_0100 -> PC 0x1000_0400, PC_plus4 was 0x1000_0014.
  - JR=1 together with JMP=1, RegRs=0x0000_2003 -> PC 0x2000 (JR wins; low bits cleared).
- Halting syscall:
  - PC=0x80, SysCALL=1, SysHalt=1, Go=1 -> PC stays 0x80, Halted=1.
  - Later Go=1 -> PC 0x84, Halted=0.
  - Non-halting syscall at 0x80 -> PC 0x84, no halt.
- Stall and async reset: En=0 for 3 edges -> PC and counters frozen. Reset_n asserted mid-HALT without a clock edge -> PC=RESET_PC, Halted=0 immediately.
- Statistics (SC_PC_STATS_EN defined): 10 RUN cycles containing 3 taken branches -> CycleCnt=10, BranchCnt=3. Macro undefined -> both read 0.
